// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, default width and counter-width helper
// for the shift-and-add multiplier.
package mul_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Step counter width. It is never narrower than 1 bit, so W=1 still
    // gets a legal vector.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit full-adder cell.
// Ports: x, y, cin (addends and carry-in); sum, cout (sum bit and carry-out).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/ripple_adder_w.sv
// ripple_adder_w: parameterised W-bit ripple-carry adder built from full_adder cells.
// Ports: x, y (W-bit addends), cin (carry-in); sum (W-bit), cout (carry-out).
module ripple_adder_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;
    assign cout = c[W];

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .x   (x[i]),
            .y   (y[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul: sequential unsigned W x W shift-and-add multiplier with valid/ready handshakes.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with 2*W-bit product; busy high while multiplying.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int CW = cnt_w(W);

    state_t          state;
    logic [W-1:0]    mcand;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;
    logic [W-1:0]    addend;
    logic [W-1:0]    sum;
    logic            c;
    logic [CW-1:0]   cnt;

    // The multiplier bits live in acc_lo and are shifted out LSB-first,
    // so acc_lo[0] always selects whether this step adds the multiplicand.
    assign addend = acc_lo[0] ? mcand : '0;

    ripple_adder_w #(.W(W)) u_add (
        .x   (acc_hi),
        .y   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(c)
    );

    assign product = {acc_hi, acc_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        acc_hi   <= '0;
                        acc_lo   <= b;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // The adder carry becomes the new MSB, so no product bit is lost.
                    {acc_hi, acc_lo} <= {c, sum, acc_lo[W-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
